bcd_to_bin: RTL and testbench

//  Sequential BCD-to-binary converter; inverse of the divider-based bin->BCD display path.

---
 rtl/bcd_to_bin_pkg.sv | 18 +
 rtl/mul10_add.sv | 13 +
 rtl/bcd_to_bin.sv | 146 ++++++++++++++
 tb/tb_bcd_to_bin.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_to_bin_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_to_bin_pkg;

  // Converter FSM states; encodings are fixed so they stay stable across builds.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StConv = 2'd1
  } state_e;

  // First non-decimal digit value.
  localparam logic [3:0] Ten = 4'd10;

  // True for digit codes 10..15, which are not valid BCD.
  function automatic logic digit_invalid(input logic [3:0] d);
    return d >= Ten;
  endfunction

endpackage

// File: rtl/mul10_add.sv
// Combinational step of the converter: sum = a*10 + d, computed as (a<<3)+(a<<1)+d.
// Result is BW bits wide and wraps modulo 2**BW.
module mul10_add #(
  parameter int unsigned BW = 10
) (
  input  logic [BW-1:0] a_i,
  input  logic [3:0]    d_i,
  output logic [BW-1:0] sum_o
);

  assign sum_o = (a_i << 3) + (a_i << 1) + BW'(d_i);

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter: one digit per clock, most-significant digit first.
// Optional feature: define BCD_CHECK_EN to flag digits above 9 (ERR=1, BIN=0 at DONE).
// Without it ERR is tied low and digits 10..15 are used as their raw value.
module bcd_to_bin
  import bcd_to_bin_pkg::*;
#(
  parameter int unsigned NDIG = 3,
  parameter int unsigned BW   = 10
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic [4*NDIG-1:0] BCD,
  output logic              RDY,
  output logic [BW-1:0]     BIN,
  output logic              DONE,
  output logic              ERR
);

  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NDIG - 1);

  state_e            state_q, state_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [BW-1:0]     acc_q, acc_d;
  logic [BW-1:0]     bin_q, bin_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [3:0]        digit;
  logic [BW-1:0]     acc_next;

`ifdef BCD_CHECK_EN
  logic bad_q, bad_d;
  logic err_q, err_d;
  logic bad_now;
`endif

  // Pick the digit addressed by the down-counter from the captured input.
  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt_q == CntW'(i)) begin
        digit = shadow_q[4*i +: 4];
      end
    end
  end

  mul10_add #(
    .BW (BW)
  ) u_mul10_add (
    .a_i   (acc_q),
    .d_i   (digit),
    .sum_o (acc_next)
  );

`ifdef BCD_CHECK_EN
  // Include the current digit so a bad last digit is still reported at DONE.
  assign bad_now = bad_q | digit_invalid(digit);
`endif

  // Next-state logic: capture on accepted START, then accumulate one digit per clock.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    acc_d    = acc_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
`ifdef BCD_CHECK_EN
    bad_d    = bad_q;
    err_d    = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (START) begin
          shadow_d = BCD;
          acc_d    = '0;
          cnt_d    = CntLast;
          state_d  = StConv;
`ifdef BCD_CHECK_EN
          bad_d    = 1'b0;
          err_d    = 1'b0;
`endif
        end
      end
      StConv: begin
        acc_d = acc_next;
`ifdef BCD_CHECK_EN
        bad_d = bad_now;
`endif
        if (cnt_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
`ifdef BCD_CHECK_EN
          bin_d   = bad_now ? '0 : acc_next;
          err_d   = bad_now;
`else
          bin_d   = acc_next;
`endif
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      acc_q    <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
`ifdef BCD_CHECK_EN
      bad_q    <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
`ifdef BCD_CHECK_EN
      bad_q    <= bad_d;
      err_q    <= err_d;
`endif
    end
  end

  assign RDY  = (state_q == StIdle);
  assign BIN  = bin_q;
  assign DONE = done_q;
`ifdef BCD_CHECK_EN
  assign ERR  = err_q;
`else
  assign ERR  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: a 3-digit and a 4-digit instance, an arithmetic
// reference model checked every cycle, and directed vectors with literal expectations.
module tb_bcd_to_bin;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        start3 = 1'b0;
  logic [11:0] bcd3 = '0;
  logic        rdy3, done3, err3;
  logic [9:0]  bin3;

  logic        start4 = 1'b0;
  logic [15:0] bcd4 = '0;
  logic        rdy4, done4, err4;
  logic [13:0] bin4;

  int total = 0;
  int bad = 0;

  bcd_to_bin #(.NDIG(3), .BW(10)) u_dut3 (
    .CLK(clk), .RSTN(rstn), .START(start3), .BCD(bcd3),
    .RDY(rdy3), .BIN(bin3), .DONE(done3), .ERR(err3)
  );

  bcd_to_bin #(.NDIG(4), .BW(14)) u_dut4 (
    .CLK(clk), .RSTN(rstn), .START(start4), .BCD(bcd4),
    .RDY(rdy4), .BIN(bin4), .DONE(done4), .ERR(err4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference value: positional decimal sum of the digits, wrapped to bw bits.
  function automatic int ref_val(input logic [15:0] b, input int nd, input int bw);
    int v = 0;
    int p = 1;
    logic [15:0] t = b;
    for (int i = 0; i < nd; i++) begin
      v += int'(t[3:0]) * p;
      p *= 10;
      t = t >> 4;
    end
    v = v % (1 << bw);
`ifdef BCD_CHECK_EN
    if (ref_err(b, nd)) v = 0;
`endif
    return v;
  endfunction

  function automatic logic ref_err(input logic [15:0] b, input int nd);
    logic e = 1'b0;
`ifdef BCD_CHECK_EN
    logic [15:0] t = b;
    for (int i = 0; i < nd; i++) begin
      if (t[3:0] > 4'd9) e = 1'b1;
      t = t >> 4;
    end
`endif
    return e;
  endfunction

  // Model: busy counts clocks left until the result appears.
  int          m3_busy, m4_busy;
  logic [31:0] m3_bin, m3_pend, m4_bin, m4_pend;
  logic        m3_done, m3_err, m3_perr, m4_done, m4_err, m4_perr;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m3_busy <= 0; m3_bin <= 0; m3_done <= 0; m3_err <= 0; m3_pend <= 0; m3_perr <= 0;
    end else begin
      m3_done <= 1'b0;
      if (m3_busy == 0) begin
        if (start3) begin
          m3_busy <= 3;
          m3_pend <= ref_val({4'h0, bcd3}, 3, 10);
          m3_perr <= ref_err({4'h0, bcd3}, 3);
          m3_err  <= 1'b0;
        end
      end else begin
        m3_busy <= m3_busy - 1;
        if (m3_busy == 1) begin
          m3_done <= 1'b1;
          m3_bin  <= m3_pend;
          m3_err  <= m3_perr;
        end
      end
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m4_busy <= 0; m4_bin <= 0; m4_done <= 0; m4_err <= 0; m4_pend <= 0; m4_perr <= 0;
    end else begin
      m4_done <= 1'b0;
      if (m4_busy == 0) begin
        if (start4) begin
          m4_busy <= 4;
          m4_pend <= ref_val(bcd4, 4, 14);
          m4_perr <= ref_err(bcd4, 4);
          m4_err  <= 1'b0;
        end
      end else begin
        m4_busy <= m4_busy - 1;
        if (m4_busy == 1) begin
          m4_done <= 1'b1;
          m4_bin  <= m4_pend;
          m4_err  <= m4_perr;
        end
      end
    end
  end

  // Compare DUT outputs against the model every cycle out of reset.
  always @(negedge clk) begin
    if (rstn) begin
      chk("rdy3", rdy3, (m3_busy == 0));
      chk("done3", done3, m3_done);
      chk("bin3", bin3, m3_bin);
      chk("err3", err3, m3_err);
      chk("rdy4", rdy4, (m4_busy == 0));
      chk("done4", done4, m4_done);
      chk("bin4", bin4, m4_bin);
      chk("err4", err4, m4_err);
    end
  end

  // Pulse START for one clock and count negedges until DONE (edge k is before negedge 1).
  task automatic run3(input logic [11:0] v, output int lat, output int rlow);
    lat = -1;
    rlow = 0;
    @(negedge clk);
    bcd3 = v;
    start3 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) start3 = 1'b0;
      if (!rdy3) rlow++;
      if (done3) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run4(input logic [15:0] v, output int lat);
    lat = -1;
    @(negedge clk);
    bcd4 = v;
    start4 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) start4 = 1'b0;
      if (done4) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rlow, ndone;
    logic [9:0] vals [2];

    // Reset state
    #12;
    chk("rst_rdy", rdy3, 1);
    chk("rst_bin", bin3, 0);
    chk("rst_done", done3, 0);
    chk("rst_err", err3, 0);
    @(negedge clk);
    rstn = 1'b1;

    // 255: DONE three clocks after the START edge, RDY low for three cycles
    run3(12'h255, lat, rlow);
    chk("t1_lat", lat, 4);
    chk("t1_rdylow", rlow, 3);
    chk("t1_bin", bin3, 255);
    chk("t1_err", err3, 0);

    // Extremes
    run3(12'h999, lat, rlow);
    chk("t2_bin999", bin3, 10'h3E7);
    run3(12'h000, lat, rlow);
    chk("t2_lat0", lat, 4);
    chk("t2_bin0", bin3, 0);

    // START held high; input change after capture must not affect first result
    ndone = 0;
    @(negedge clk);
    bcd3 = 12'h255;
    start3 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) bcd3 = 12'h123;
      if (i == 5) start3 = 1'b0;
      if (done3) begin
        if (ndone < 2) vals[ndone] = bin3;
        ndone++;
      end
    end
    chk("t3_ndone", ndone, 2);
    chk("t3_first", vals[0], 255);
    chk("t3_second", vals[1], 123);

    // Non-decimal digit
    run3(12'h1A3, lat, rlow);
`ifdef BCD_CHECK_EN
    chk("t4_err", err3, 1);
    chk("t4_bin", bin3, 0);
`else
    chk("t4_err", err3, 0);
    chk("t4_bin", bin3, 203);
`endif
    run3(12'h042, lat, rlow);
    chk("t4_err2", err3, 0);
    chk("t4_bin2", bin3, 42);

    // Reset during the second conversion cycle
    @(negedge clk);
    bcd3 = 12'h255;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t5_bin", bin3, 0);
    chk("t5_done", done3, 0);
    chk("t5_rdy", rdy3, 1);
    @(negedge clk);
    rstn = 1'b1;
    run3(12'h007, lat, rlow);
    chk("t5_lat", lat, 4);
    chk("t5_bin7", bin3, 7);

    // Four-digit instance
    run4(16'h9999, lat);
    chk("t6_lat", lat, 5);
    chk("t6_bin", bin4, 9999);
    run4(16'h1234, lat);
    chk("t6_bin2", bin4, 1234);

    // Pin the model itself
    chk("model_wrap", ref_val(16'h0999, 3, 10), 999);
    chk("model_4d", ref_val(16'h0305, 4, 14), 305);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
